// File: rtl/csr_mmio_router.sv
// csr_mmio_router: CCI-P MMIO fan-out to NUM_SUB sub-CSR channels with a merged read-response stream.
// Optional stalled-read timeout is compiled in with `define CSR_ROUTER_TIMEOUT_EN.
package csr_mmio_router_pkg;
    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_mmio_req_hdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_mmio_rsp_hdr;

    typedef struct packed {
        t_mmio_req_hdr hdr;
        logic [63:0]   data;
        logic          rdValid;
        logic          wrValid;
    } t_sub_csr_rx;

    typedef struct packed {
        t_mmio_rsp_hdr hdr;
        logic [63:0]   data;
        logic          mmioRdValid;
    } t_sub_csr_tx;

    localparam int RX_W = $bits(t_sub_csr_rx);
    localparam int TX_W = $bits(t_sub_csr_tx);
endpackage

module csr_mmio_router
    import csr_mmio_router_pkg::*;
#(
    parameter int          NUM_SUB        = 4,
    parameter logic [15:0] BASE_ADDR      = 16'h0000,
    parameter int          SUB_ADDR_BITS  = 8,
    parameter int          RSP_DEPTH      = 64,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [RX_W-1:0]                afu_rx,
    output logic [TX_W-1:0]                afu_tx,
    output logic [NUM_SUB-1:0][RX_W-1:0]   sub_rx,
    input  logic [NUM_SUB-1:0][TX_W-1:0]   sub_tx,
    output logic                           err_ovf,
    output logic                           err_timeout
);
    localparam int NCH   = NUM_SUB + 1;
    localparam int CH_W  = $clog2(NCH);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int ENT_W = 9 + 64;
    localparam logic [15:0]  WIN_MASK = 16'((33'd1 << SUB_ADDR_BITS) - 33'd1);
    localparam logic [PTR_W:0] PTR_ONE = 1;
    localparam logic [CH_W-1:0] CH_ONE = 1;

    t_sub_csr_rx req;
    t_sub_csr_rx fwd;
    logic [15:0] off;
    logic [31:0] idxWide;
    logic [CH_W-1:0] idx;
    logic mapped;
    logic rdEff;
    logic [NUM_SUB-1:0] selOh;

    assign req     = t_sub_csr_rx'(afu_rx);
    assign off     = req.hdr.address - BASE_ADDR;
    assign idxWide = 32'(off) >> SUB_ADDR_BITS;
    assign idx     = idxWide[CH_W-1:0];
    assign mapped  = (req.hdr.address >= BASE_ADDR) && (idxWide < 32'(NUM_SUB));
    // A write wins over a read presented in the same cycle.
    assign rdEff   = req.rdValid & ~req.wrValid;
    assign selOh   = mapped ? (NUM_SUB'(1) << idx) : '0;

    always_comb begin
        fwd = req;
        fwd.hdr.address = off & WIN_MASK;
        fwd.rdValid = 1'b0;
        fwd.wrValid = 1'b0;
    end

    // ---- stage p1: registered per-sub requests ----
    t_sub_csr_rx subRx_p1 [NUM_SUB];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SUB; i++) begin
            if (reset) begin
                subRx_p1[i] <= '0;
            end else begin
                subRx_p1[i]         <= fwd;
                subRx_p1[i].rdValid <= selOh[i] & rdEff;
                subRx_p1[i].wrValid <= selOh[i] & req.wrValid;
            end
        end
    end

    // ---- response FIFOs: channels 0..NUM_SUB-1 are subs, NUM_SUB is the local queue ----
    t_sub_csr_tx subTx [NUM_SUB];
    logic [NCH-1:0] pushVld;
    logic [ENT_W-1:0] pushEnt [NCH];
    logic [ENT_W-1:0] mem [NCH][RSP_DEPTH];
    logic [PTR_W:0] wrPtr [NCH];
    logic [PTR_W:0] rdPtr [NCH];
    logic [NCH-1:0] empty, full, popOh, pushOk, ovfVec;
    logic grantVld;
    logic [CH_W-1:0] grant, rrPtr;
    logic errOvf;

    assign pushVld[NUM_SUB] = rdEff & ~mapped;
    assign pushEnt[NUM_SUB] = {req.hdr.tid, 64'h0};

`ifdef CSR_ROUTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [NUM_SUB-1:0] fireVec;
    logic errTimeout;
`endif

    genvar g;
    for (g = 0; g < NUM_SUB; g++) begin : gSub
        assign subTx[g]  = t_sub_csr_tx'(sub_tx[g]);
        assign sub_rx[g] = subRx_p1[g];
`ifdef CSR_ROUTER_TIMEOUT_EN
        logic [8:0] pendMem [RSP_DEPTH];
        logic [PTR_W:0] pendWr, pendRd;
        logic [15:0] timer, dropCnt;
        logic pendEmpty, pendFull, dropping, deliver, fire, pendPop, pendPush;

        assign pendEmpty = (pendWr == pendRd);
        assign pendFull  = (pendWr[PTR_W] != pendRd[PTR_W]) && (pendWr[PTR_W-1:0] == pendRd[PTR_W-1:0]);
        assign dropping  = subTx[g].mmioRdValid && (dropCnt != 16'd0);
        assign deliver   = subTx[g].mmioRdValid && (dropCnt == 16'd0);
        // A real response in the same cycle always suppresses the timeout.
        assign fire      = !pendEmpty && !subTx[g].mmioRdValid && (timer >= TMO_LAST);
        assign pendPop   = (deliver && !pendEmpty) || fire;
        assign pendPush  = selOh[g] & rdEff;
        assign fireVec[g] = fire;

        assign pushVld[g] = deliver | fire;
        assign pushEnt[g] = fire ? {pendMem[pendRd[PTR_W-1:0]], 64'hDEAD_DEAD_DEAD_DEAD}
                                 : {subTx[g].hdr.tid, subTx[g].data};

        always_ff @(posedge clk) begin
            if (pendPush && (!pendFull || pendPop))
                pendMem[pendWr[PTR_W-1:0]] <= req.hdr.tid;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                pendWr  <= '0;
                pendRd  <= '0;
                timer   <= '0;
                dropCnt <= '0;
            end else begin
                if (pendPush && (!pendFull || pendPop)) pendWr <= pendWr + PTR_ONE;
                if (pendPop) pendRd <= pendRd + PTR_ONE;
                if (pendPop || pendEmpty) timer <= '0;
                else if (timer != 16'hFFFF) timer <= timer + 16'd1;
                if (fire && (dropCnt != 16'hFFFF)) dropCnt <= dropCnt + 16'd1;
                else if (dropping) dropCnt <= dropCnt - 16'd1;
            end
        end
`else
        assign pushVld[g] = subTx[g].mmioRdValid;
        assign pushEnt[g] = {subTx[g].hdr.tid, subTx[g].data};
`endif
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            empty[c] = (wrPtr[c] == rdPtr[c]);
            full[c]  = (wrPtr[c][PTR_W] != rdPtr[c][PTR_W]) &&
                       (wrPtr[c][PTR_W-1:0] == rdPtr[c][PTR_W-1:0]);
        end
    end

    // Round-robin: lowest offset from rrPtr wins, so scan offsets downward.
    always_comb begin
        int j;
        j = 0;
        grantVld = 1'b0;
        grant = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            j = int'(rrPtr) + k;
            if (j >= NCH) j = j - NCH;
            if (!empty[j]) begin
                grantVld = 1'b1;
                grant = CH_W'(j);
            end
        end
    end

    assign popOh  = grantVld ? (NCH'(1) << grant) : '0;
    assign pushOk = pushVld & (~full | popOh);
    assign ovfVec = pushVld & full & ~popOh;

    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (pushOk[c]) mem[c][wrPtr[c][PTR_W-1:0]] <= pushEnt[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                wrPtr[c] <= '0;
                rdPtr[c] <= '0;
            end
            rrPtr  <= '0;
            errOvf <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (pushOk[c]) wrPtr[c] <= wrPtr[c] + PTR_ONE;
                if (popOh[c])  rdPtr[c] <= rdPtr[c] + PTR_ONE;
            end
            if (grantVld) rrPtr <= (grant == CH_W'(NUM_SUB)) ? '0 : grant + CH_ONE;
            if (|ovfVec) errOvf <= 1'b1;
        end
    end

    // ---- stage p2: registered merged response ----
    t_sub_csr_tx afuTx_p2;
    logic [ENT_W-1:0] headEnt;

    assign headEnt = mem[grant][rdPtr[grant][PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            afuTx_p2 <= '0;
        end else begin
            afuTx_p2.mmioRdValid <= grantVld;
            if (grantVld) begin
                afuTx_p2.hdr.tid <= headEnt[ENT_W-1:64];
                afuTx_p2.data    <= headEnt[63:0];
            end
        end
    end

    assign afu_tx  = afuTx_p2;
    assign err_ovf = errOvf;

`ifdef CSR_ROUTER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) errTimeout <= 1'b0;
        else if (|fireVec) errTimeout <= 1'b1;
    end
    assign err_timeout = errTimeout;
`else
    // Timeout hardware is absent; the comparison only keeps TIMEOUT_CYCLES referenced.
    assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_csr_mmio_router.sv
// tb_csr_mmio_router: directed and randomized checks of csr_mmio_router against a queue-level reference model.
`timescale 1ns/1ps
module tb_csr_mmio_router;
    import csr_mmio_router_pkg::*;

    localparam int          NSUB  = 4;
    localparam logic [15:0] BASE  = 16'h0100;
    localparam int          SAB   = 8;
    localparam int          DEPTH = 4;
    localparam int          TMO   = 16;
    localparam int          NCH   = NSUB + 1;

    logic clk = 1'b0;
    logic reset;
    logic [RX_W-1:0] afu_rx;
    logic [TX_W-1:0] afu_tx;
    logic [NSUB-1:0][RX_W-1:0] sub_rx;
    logic [NSUB-1:0][TX_W-1:0] sub_tx;
    logic err_ovf, err_timeout;

    t_sub_csr_rx req;
    t_sub_csr_tx rsp [NSUB];
    t_sub_csr_tx afuTxS;

    always_comb begin
        afu_rx = req;
        for (int i = 0; i < NSUB; i++) sub_tx[i] = rsp[i];
    end
    assign afuTxS = t_sub_csr_tx'(afu_tx);

    csr_mmio_router #(
        .NUM_SUB(NSUB), .BASE_ADDR(BASE), .SUB_ADDR_BITS(SAB),
        .RSP_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .afu_rx(afu_rx), .afu_tx(afu_tx),
        .sub_rx(sub_rx), .sub_tx(sub_tx), .err_ovf(err_ovf), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per channel, a round-robin pointer, sticky overflow.
    logic [72:0] mq [NCH][$];
    int  ptr = 0;
    bit  ovfM = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit isMapped(input logic [15:0] a);
        int ai = int'(a);
        int bi = int'(BASE);
        return (ai >= bi) && (((ai - bi) / (1 << SAB)) < NSUB);
    endfunction

    task automatic qpush(input int ch, input logic [72:0] e);
        if (mq[ch].size() < DEPTH) mq[ch].push_back(e);
        else ovfM = 1;
    endtask

    task automatic clearIn();
        req = '0;
        for (int i = 0; i < NSUB; i++) rsp[i] = '0;
    endtask

    // Predict the effect of the current inputs at the next edge, then check after it.
    task automatic step();
        bit wasReset, popped, mapped, rdE, wrE;
        logic [72:0] popEnt;
        int ai, idx, j;
        t_sub_csr_rx r, got;
        r = req;
        wasReset = reset;
        popped = 0;
        popEnt = '0;
        ai = int'(r.hdr.address);
        mapped = isMapped(r.hdr.address);
        idx = mapped ? (ai - int'(BASE)) / (1 << SAB) : -1;
        rdE = r.rdValid && !r.wrValid;
        wrE = r.wrValid;
        if (wasReset) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            ptr = 0;
            ovfM = 0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                j = (ptr + k) % NCH;
                if (!popped && mq[j].size() > 0) begin
                    popEnt = mq[j].pop_front();
                    popped = 1;
                    ptr = (j + 1) % NCH;
                end
            end
            for (int i = 0; i < NSUB; i++)
                if (rsp[i].mmioRdValid) qpush(i, {rsp[i].hdr.tid, rsp[i].data});
            if (rdE && !mapped) qpush(NSUB, {r.hdr.tid, 64'h0});
        end
        @(posedge clk);
        #1;
        if (wasReset) begin
            chk("rst_afu_tx", afu_tx, '0);
            chk("rst_sub_rx", sub_rx, '0);
        end else begin
            chk("afu_vld", afuTxS.mmioRdValid, popped);
            if (popped) begin
                chk("afu_tid", afuTxS.hdr.tid, popEnt[72:64]);
                chk("afu_data", afuTxS.data, popEnt[63:0]);
            end
            for (int i = 0; i < NSUB; i++) begin
                got = t_sub_csr_rx'(sub_rx[i]);
                chk("sub_valids", {got.rdValid, got.wrValid},
                    {rdE && (idx == i), wrE && (idx == i)});
                if ((rdE || wrE) && idx == i) begin
                    chk("sub_addr", got.hdr.address, 16'((ai - int'(BASE)) % (1 << SAB)));
                    chk("sub_tid", got.hdr.tid, r.hdr.tid);
                    chk("sub_len", got.hdr.length, r.hdr.length);
                    chk("sub_data", got.data, r.data);
                end
            end
        end
        chk("err_ovf", err_ovf, ovfM);
`ifndef CSR_ROUTER_TIMEOUT_EN
        chk("err_timeout", err_timeout, 1'b0);
`endif
    endtask

    initial begin
        bit seen;
        int extra;
        reset = 1'b1;
        clearIn();
        for (int n = 0; n < 3; n++) step();
        reset = 1'b0;
        step();

        // Routing: write to 0x0234 lands on sub 1, window address 0x34.
        req.wrValid = 1'b1; req.hdr.address = 16'h0234; req.data = 64'h1234; req.hdr.tid = 9'h011;
        step();
        clearIn();
        step();

        // Unmapped read answered locally at t+2.
        req.rdValid = 1'b1; req.hdr.address = 16'h00F0; req.hdr.tid = 9'h05; req.data = 64'hFFFF;
        step();
        clearIn();
        step();
        step();

        // Arbitration: subs 0, 2, 3 respond together.
        rsp[0].mmioRdValid = 1'b1; rsp[0].hdr.tid = 9'd1; rsp[0].data = 64'hA0;
        rsp[2].mmioRdValid = 1'b1; rsp[2].hdr.tid = 9'd2; rsp[2].data = 64'hA2;
        rsp[3].mmioRdValid = 1'b1; rsp[3].hdr.tid = 9'd3; rsp[3].data = 64'hA3;
        step();
        clearIn();
        for (int n = 0; n < 5; n++) step();

        // Overflow: every channel pushes each cycle, so sub 0 is starved by the others.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NSUB; i++) begin
                rsp[i].mmioRdValid = 1'b1;
                rsp[i].hdr.tid = 9'(c * 8 + i);
                rsp[i].data = 64'(c * 256 + i);
            end
            req.rdValid = 1'b1; req.hdr.address = 16'h0010; req.hdr.tid = 9'(c + 100);
            step();
        end
        clearIn();
        for (int n = 0; n < 30; n++) step();
        chk("err_ovf_sticky", err_ovf, 1'b1);

        // Reset with three responses queued.
        for (int i = 0; i < 3; i++) begin
            rsp[i].mmioRdValid = 1'b1; rsp[i].hdr.tid = 9'(20 + i); rsp[i].data = 64'(i + 7);
        end
        step();
        clearIn();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int n = 0; n < 4; n++) step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int r;
            clearIn();
            req.hdr.address = 16'($urandom_range(0, 16'h05FF));
            req.hdr.length = 2'($urandom);
            req.hdr.tid = 9'($urandom);
            req.data = {$urandom(), $urandom()};
            r = $urandom_range(0, 9);
            req.rdValid = (r < 4) || (r == 8);
            req.wrValid = (r >= 4) && (r <= 8);
`ifdef CSR_ROUTER_TIMEOUT_EN
            if (req.rdValid && !req.wrValid && isMapped(req.hdr.address)) req.rdValid = 1'b0;
`endif
            for (int i = 0; i < NSUB; i++) begin
                rsp[i].mmioRdValid = ($urandom_range(0, 3) == 0);
                rsp[i].hdr.tid = 9'($urandom);
                rsp[i].data = {$urandom(), $urandom()};
            end
            step();
        end
        clearIn();
        for (int n = 0; n < 20; n++) step();

`ifdef CSR_ROUTER_TIMEOUT_EN
        // Timeout: read to sub 2 with no reply.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        req.rdValid = 1'b1; req.hdr.address = 16'h0305; req.hdr.tid = 9'h07;
        @(posedge clk);
        #1;
        clearIn();
        seen = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (afuTxS.mmioRdValid) seen = 1;
        end
        chk("tmo_seen", seen, 1'b1);
        chk("tmo_tid", afuTxS.hdr.tid, 9'h07);
        chk("tmo_data", afuTxS.data, 64'hDEAD_DEAD_DEAD_DEAD);
        chk("tmo_err", err_timeout, 1'b1);
        rsp[2].mmioRdValid = 1'b1; rsp[2].hdr.tid = 9'h07; rsp[2].data = 64'h55;
        @(posedge clk);
        #1;
        clearIn();
        extra = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (afuTxS.mmioRdValid) extra++;
        end
        chk("tmo_late_drop", extra, 0);
        chk("tmo_err_sticky", err_timeout, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/csr_mmio_router.md
# csr_mmio_router

Parametrised CCI-P MMIO fan-out between the AFU CSR port and `NUM_SUB` sub-CSR blocks, each on its own `sub_csr_if`-format channel. It decodes each MMIO read/write address into a per-sub window and forwards the request, registered, with a window-local address. It merges the subs' read responses through per-channel FIFOs and a round-robin arbiter into one AFU response stream. Unmapped reads are answered locally. Optionally, stalled reads are answered by a timeout.

## Interface
- `NUM_SUB`, 4: number of sub-CSR channels, 1..16.
- `BASE_ADDR`, 16'h0000: first MMIO dword address routed; 4-byte units, as in the CCI-P header.
- `SUB_ADDR_BITS`, 8: window size per sub is 2^`SUB_ADDR_BITS` dwords.
- `RSP_DEPTH`, 64: depth of each response FIFO, power of 2, ≥ 2.
- `TIMEOUT_CYCLES`, 4096: read timeout; used only with `CSR_ROUTER_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `afu_rx` in `t_sub_csr_rx`: MMIO request from the AFU. Fields are `hdr`, `data`, `rdValid`, `wrValid`.
- `afu_tx` out `t_sub_csr_tx`: merged MMIO read response.
- `sub_rx[NUM_SUB]` out `t_sub_csr_rx`: per-sub requests.
- `sub_tx[NUM_SUB]` in `t_sub_csr_tx`: per-sub responses. No backpressure.
- `err_ovf` out 1: sticky; set when a response FIFO overflows.
- `err_timeout` out 1: sticky; set when any read times out.

## Operation
- Decode:
  - `off = hdr.address - BASE_ADDR`.
  - `idx = off >> SUB_ADDR_BITS`.
  - The request is mapped iff `hdr.address >= BASE_ADDR` and `idx < NUM_SUB`.
- Mapped request: forwarded to `sub_rx[idx]` only.
  - `hdr.address` is replaced by `off[SUB_ADDR_BITS-1:0]`, zero-extended.
  - `length`, `tid`, `data`, `rdValid` and `wrValid` are unchanged.
  - All other subs see `rdValid = wrValid = 0`.
- Unmapped write: dropped.
- Unmapped read: `{tid, data = 64'h0}` is pushed into the local queue (channel `NUM_SUB`).
- Response path:
  - Each `sub_tx[i].mmioRdValid` pushes `{hdr.tid, data}` into FIFO i.
  - Round-robin arbitration runs over FIFOs 0..`NUM_SUB`. One pop per cycle.
  - After a grant, the pointer moves to grantee+1 (mod `NUM_SUB`+1).
  - The popped entry drives `afu_tx` for exactly one cycle with `mmioRdValid = 1`.
- Overflow: a push to a full FIFO is dropped and sets `err_ovf`. A simultaneous push and pop on a full FIFO is not an overflow.
- `rdValid` and `wrValid` both high in the same cycle: the write takes precedence, and the read is dropped. This violates the CCI-P protocol.

## Timing
- Request: `afu_rx` at cycle t appears on `sub_rx[idx]` at t+1, fully registered.
- Response, uncontended: `sub_tx` valid at t gives `afu_tx.mmioRdValid` at t+2.
- Unmapped read: request at t gives response at t+2.
- Throughput: one request and one response per cycle sustained.
- FIFO entries are never reordered within a channel.
- Reset values:
  - `afu_tx` all zeros.
  - All `sub_rx` valids 0; data and headers 0.
  - FIFOs empty; arbiter pointer 0; `err_ovf` and `err_timeout` 0.
- Reset mid-operation: in-flight requests and queued responses are discarded, and no response is emitted in the cycle after `reset` deasserts.

## Configuration
- Macro: `CSR_ROUTER_TIMEOUT_EN`.
- Defined:
  - Each sub has a pending-tid queue of depth `RSP_DEPTH`, pushed on every forwarded read. This adds a 16-bit-wide `TIMEOUT_CYCLES`-range timer per sub.
  - The timer clears when the queue head changes and counts while the queue is non-empty.
  - When the timer reaches `TIMEOUT_CYCLES-1`:
    - The head tid is popped.
    - `{tid, 64'hDEAD_DEAD_DEAD_DEAD}` is pushed into FIFO i.
    - `err_timeout` is set.
    - The sub's drop counter is incremented.
  - Each later sub response with drop counter > 0 is discarded and decrements the counter.
  - A real response that arrives in the same cycle as the timeout is the one delivered, and the timeout is suppressed.
  - A normal sub response pops the pending queue head.
- Undefined: no pending queues, timers or drop counters; `err_timeout` is tied to 0.

## Test plan
- Routing: `NUM_SUB=4`, `BASE_ADDR=16'h0100`, `SUB_ADDR_BITS=8`. A write to `16'h0234` with `data=64'h1234` → at t+1 only `sub_rx[1].wrValid`, with `address=16'h0034` and `data=64'h1234`.
- Unmapped read: read to `16'h00F0` with `tid=9'h05` → at t+2, `afu_tx` has `tid=5` and `data=0`; no `sub_rx` valid ever asserted.
- Arbitration: subs 0, 2 and 3 respond in the same cycle with tids 1, 2 and 3, pointer at 0 → `afu_tx` carries tids 1, 2, 3 on consecutive cycles.
- Overflow: `RSP_DEPTH=4`; sub 0 returns 6 responses while the arbiter is starved → first 4 delivered, `err_ovf=1`.
- Timeout (macro on, `TIMEOUT_CYCLES=16`): read `tid=9'h07` to sub 2 with no reply → `afu_tx` carries `tid=7`, `data=64'hDEAD_DEAD_DEAD_DEAD`, `err_timeout=1`; a later sub 2 reply is dropped.
- Reset mid-stream: assert `reset` with 3 responses queued → no `afu_tx` valid after release, all outputs zero.
